// File: rtl/lock_access_ctrl.sv
// Keypad combination lock controller.
// Accepts three keypad digits through a valid/ready handshake and compares
// them against CODE0..CODE2. A match opens the lock for OPEN_CYCLES cycles.
// MAX_FAIL consecutive wrong entries enter a LOCKOUT of LOCKOUT_CYCLES cycles.
// A partial entry is aborted by cancel or by ENTRY_TIMEOUT idle cycles.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   digit[2:0]    in   keypad digit
//   digit_valid   in   digit offered
//   digit_ready   out  controller accepts a digit (IDLE/GOT1/GOT2, from state)
//   cancel        in   abort current entry (effective in GOT1/GOT2 only)
//   unlock        out  lock open (state == OPEN)
//   fail_pulse    out  one-cycle pulse per wrong 3-digit entry
//   alarm_pulse   out  one-cycle pulse on lockout entry
//   timeout_pulse out  one-cycle pulse on entry timeout
//   locked_out    out  lockout active (state == LOCKOUT)
//   fail_count    out  consecutive failures so far
//   state[2:0]    out  current FSM state
module lock_access_ctrl #(
    parameter logic [2:0]  CODE0          = 3'b011,
    parameter logic [2:0]  CODE1          = 3'b111,
    parameter logic [2:0]  CODE2          = 3'b101,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned ENTRY_TIMEOUT  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] digit,
    input  logic       digit_valid,
    output logic       digit_ready,
    input  logic       cancel,
    output logic       unlock,
    output logic       fail_pulse,
    output logic       alarm_pulse,
    output logic       timeout_pulse,
    output logic       locked_out,
    output logic [1:0] fail_count,
    output logic [2:0] state
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned FAIL_W  = 2;
    localparam int unsigned DIGIT_W = 3;

    localparam logic [CNT_W-1:0]  OPEN_LOAD    = CNT_W'(OPEN_CYCLES);
    localparam logic [CNT_W-1:0]  LOCK_LOAD    = CNT_W'(LOCKOUT_CYCLES);
    // Timeout fires on the idle edge that would bring the counter to ENTRY_TIMEOUT.
    localparam logic [CNT_W-1:0]  IDLE_LAST    = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [FAIL_W:0]   FAIL_LIMIT   = (FAIL_W + 1)'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_SAT     = FAIL_W'(MAX_FAIL);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GOT1    = 3'd1,
        GOT2    = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t               state_q, state_nxt;
    logic [CNT_W-1:0]     timer_q, timer_nxt;
    logic [CNT_W-1:0]     idle_q, idle_nxt;
    logic [FAIL_W-1:0]    fail_q, fail_nxt;
    logic [DIGIT_W-1:0]   d0_q, d0_nxt;
    logic [DIGIT_W-1:0]   d1_q, d1_nxt;
    logic [DIGIT_W-1:0]   d2_q, d2_nxt;
    logic                 fail_p_nxt, alarm_p_nxt, timeout_p_nxt;
    logic                 accept;
    logic [FAIL_W:0]      fail_inc;
    logic                 code_match;

    // Ready is a pure decode of the state register.
    assign digit_ready = (state_q == IDLE) || (state_q == GOT1) || (state_q == GOT2);
    assign accept      = digit_valid && digit_ready;
    assign fail_inc    = {1'b0, fail_q} + (FAIL_W + 1)'(1);
    assign code_match  = (d0_q == CODE0) && (d1_q == CODE1) && (digit == CODE2);

    assign state      = state_q;
    assign fail_count = fail_q;

    // State, counters, stored digits and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            idle_q        <= '0;
            fail_q        <= '0;
            d0_q          <= '0;
            d1_q          <= '0;
            d2_q          <= '0;
            unlock        <= 1'b0;
            locked_out    <= 1'b0;
            fail_pulse    <= 1'b0;
            alarm_pulse   <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            timer_q       <= timer_nxt;
            idle_q        <= idle_nxt;
            fail_q        <= fail_nxt;
            d0_q          <= d0_nxt;
            d1_q          <= d1_nxt;
            d2_q          <= d2_nxt;
            unlock        <= (state_nxt == OPEN);
            locked_out    <= (state_nxt == LOCKOUT);
            fail_pulse    <= fail_p_nxt;
            alarm_pulse   <= alarm_p_nxt;
            timeout_pulse <= timeout_p_nxt;
        end
    end

    // Next-state logic. Priority inside an entry: cancel, then digit, then timeout.
    always_comb begin
        state_nxt     = state_q;
        timer_nxt     = timer_q;
        idle_nxt      = idle_q;
        fail_nxt      = fail_q;
        d0_nxt        = d0_q;
        d1_nxt        = d1_q;
        d2_nxt        = d2_q;
        fail_p_nxt    = 1'b0;
        alarm_p_nxt   = 1'b0;
        timeout_p_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                idle_nxt = '0;
                if (accept) begin
                    d0_nxt    = digit;
                    state_nxt = GOT1;
                end
            end

            GOT1: begin
                if (cancel) begin
                    // A digit handshaking alongside cancel is dropped.
                    idle_nxt  = '0;
                    state_nxt = IDLE;
                end else if (accept) begin
                    d1_nxt    = digit;
                    idle_nxt  = '0;
                    state_nxt = GOT2;
                end else if (idle_q >= IDLE_LAST) begin
                    idle_nxt      = '0;
                    timeout_p_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    idle_nxt = idle_q + CNT_W'(1);
                end
            end

            GOT2: begin
                if (cancel) begin
                    idle_nxt  = '0;
                    state_nxt = IDLE;
                end else if (accept) begin
                    d2_nxt   = digit;
                    idle_nxt = '0;
                    if (code_match) begin
                        fail_nxt  = '0;
                        timer_nxt = OPEN_LOAD;
                        state_nxt = OPEN;
                    end else if (fail_inc >= FAIL_LIMIT) begin
                        fail_nxt    = FAIL_SAT;
                        fail_p_nxt  = 1'b1;
                        alarm_p_nxt = 1'b1;
                        timer_nxt   = LOCK_LOAD;
                        state_nxt   = LOCKOUT;
                    end else begin
                        fail_nxt   = fail_inc[FAIL_W-1:0];
                        fail_p_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end
                end else if (idle_q >= IDLE_LAST) begin
                    idle_nxt      = '0;
                    timeout_p_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    idle_nxt = idle_q + CNT_W'(1);
                end
            end

            OPEN: begin
                // Loaded with the duration on entry; the cycle showing 1 is the last.
                if (timer_q <= CNT_W'(1)) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer_q - CNT_W'(1);
                end
            end

            LOCKOUT: begin
                if (timer_q <= CNT_W'(1)) begin
                    timer_nxt = '0;
                    fail_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer_q - CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed bench for lock_access_ctrl with default parameters
// (code 011,111,101; MAX_FAIL 3; OPEN 8; LOCKOUT 16; ENTRY_TIMEOUT 32).
module tb_lock_access_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       cancel;
    logic       unlock;
    logic       fail_pulse;
    logic       alarm_pulse;
    logic       timeout_pulse;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [2:0] state;

    int n_pass  = 0;
    int n_total = 0;

    lock_access_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .digit_ready   (digit_ready),
        .cancel        (cancel),
        .unlock        (unlock),
        .fail_pulse    (fail_pulse),
        .alarm_pulse   (alarm_pulse),
        .timeout_pulse (timeout_pulse),
        .locked_out    (locked_out),
        .fail_count    (fail_count),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        digit_valid = 1'b1;
        digit = a; step();
        digit = b; step();
        digit = c; step();
        digit_valid = 1'b0;
    endtask

    // Counts cycles with unlock high over a bounded window, starting from now.
    task automatic count_unlock(output int n);
        n = 0;
        for (int i = 0; i < 24; i++) begin
            if (unlock) n++;
            step();
        end
    endtask

    int n;
    int ready_bad;

    initial begin
        reset       = 1'b1;
        digit       = 3'd0;
        digit_valid = 1'b0;
        cancel      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",   8'(state), 8'd0);
        chk("rst_unlock",  8'(unlock), 8'd0);
        chk("rst_locked",  8'(locked_out), 8'd0);
        chk("rst_fail",    8'(fail_count), 8'd0);
        chk("rst_pulses",  8'({fail_pulse, alarm_pulse, timeout_pulse}), 8'd0);
        reset = 1'b0;
        step();
        chk("idle_ready",  8'(digit_ready), 8'd1);

        // Correct entry
        digit_valid = 1'b1;
        digit = 3'b011; step();
        chk("got1", 8'(state), 8'd1);
        digit = 3'b111; step();
        chk("got2", 8'(state), 8'd2);
        digit = 3'b101; step();
        digit_valid = 1'b0;
        chk("open_state",  8'(state), 8'd3);
        chk("open_unlock", 8'(unlock), 8'd1);
        chk("open_ready",  8'(digit_ready), 8'd0);
        count_unlock(n);
        chk("open_cycles", 8'(n), 8'd8);
        chk("open_exit_state", 8'(state), 8'd0);
        chk("open_exit_fail",  8'(fail_count), 8'd0);

        // Single wrong entry
        enter(3'b011, 3'b111, 3'b100);
        chk("wrong1_pulse",  8'(fail_pulse), 8'd1);
        chk("wrong1_alarm",  8'(alarm_pulse), 8'd0);
        chk("wrong1_count",  8'(fail_count), 8'd1);
        chk("wrong1_state",  8'(state), 8'd0);
        chk("wrong1_unlock", 8'(unlock), 8'd0);
        step();
        chk("wrong1_pulse_end", 8'(fail_pulse), 8'd0);

        // Second and third wrong entries lead to lockout
        enter(3'b000, 3'b000, 3'b000);
        chk("wrong2_count", 8'(fail_count), 8'd2);
        chk("wrong2_alarm", 8'(alarm_pulse), 8'd0);
        step();
        enter(3'b011, 3'b111, 3'b110);
        chk("lock_state", 8'(state), 8'd4);
        chk("lock_pulses", 8'({fail_pulse, alarm_pulse}), 8'd3);
        chk("lock_flag",  8'(locked_out), 8'd1);
        chk("lock_count_sat", 8'(fail_count), 8'd3);
        n = 0;
        ready_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (locked_out) begin
                n++;
                if (digit_ready) ready_bad++;
            end
            step();
        end
        chk("lock_cycles",    8'(n), 8'd16);
        chk("lock_ready_low", 8'(ready_bad), 8'd0);
        chk("lock_exit_state", 8'(state), 8'd0);
        chk("lock_exit_fail",  8'(fail_count), 8'd0);

        // Correct entry clears a nonzero failure count
        enter(3'b001, 3'b010, 3'b011);
        chk("pre_clear_fail", 8'(fail_count), 8'd1);
        step();
        enter(3'b011, 3'b111, 3'b101);
        chk("clear_fail", 8'(fail_count), 8'd0);
        count_unlock(n);
        chk("clear_open_cycles", 8'(n), 8'd8);
        enter(3'b111, 3'b111, 3'b111);
        chk("fail_again", 8'(fail_count), 8'd1);
        step();

        // Entry timeout leaves the failure count alone
        digit_valid = 1'b1; digit = 3'b011; step();
        digit_valid = 1'b0;
        repeat (31) step();
        chk("to_not_yet", 8'(state), 8'd1);
        step();
        chk("to_state", 8'(state), 8'd0);
        chk("to_pulse", 8'(timeout_pulse), 8'd1);
        chk("to_fail",  8'(fail_count), 8'd1);
        step();
        chk("to_pulse_end", 8'(timeout_pulse), 8'd0);

        // Digit arriving on the timeout edge wins
        digit_valid = 1'b1; digit = 3'b011; step();
        digit_valid = 1'b0;
        repeat (31) step();
        digit_valid = 1'b1; digit = 3'b111; step();
        digit_valid = 1'b0;
        chk("digit_wins_state", 8'(state), 8'd2);
        chk("digit_wins_pulse", 8'(timeout_pulse), 8'd0);

        // Cancel with a handshaking third digit discards it
        digit_valid = 1'b1; digit = 3'b101; cancel = 1'b1; step();
        digit_valid = 1'b0; cancel = 1'b0;
        chk("cancel_state",  8'(state), 8'd0);
        chk("cancel_unlock", 8'(unlock), 8'd0);
        chk("cancel_fail_p", 8'(fail_pulse), 8'd0);
        chk("cancel_fail",   8'(fail_count), 8'd1);
        step();
        chk("cancel_unlock_late", 8'(unlock), 8'd0);

        // Cancel beats a simultaneous timeout
        digit_valid = 1'b1; digit = 3'b011; step();
        digit_valid = 1'b0;
        repeat (31) step();
        cancel = 1'b1; step();
        cancel = 1'b0;
        chk("cancel_vs_to_state", 8'(state), 8'd0);
        chk("cancel_vs_to_pulse", 8'(timeout_pulse), 8'd0);

        // Cancel in IDLE is ignored; the digit is accepted
        cancel = 1'b1; digit_valid = 1'b1; digit = 3'b011; step();
        digit_valid = 1'b0;
        chk("cancel_idle_ignored", 8'(state), 8'd1);
        step();
        cancel = 1'b0;
        chk("cancel_got1", 8'(state), 8'd0);

        // Reset in the middle of OPEN aborts immediately
        enter(3'b011, 3'b111, 3'b101);
        step(); step(); step();
        chk("mid_open_unlock", 8'(unlock), 8'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_unlock", 8'(unlock), 8'd0);
        chk("async_rst_state",  8'(state), 8'd0);
        chk("async_rst_fail",   8'(fail_count), 8'd0);
        step();
        reset = 1'b0;
        enter(3'b011, 3'b111, 3'b101);
        chk("post_rst_unlock", 8'(unlock), 8'd1);
        count_unlock(n);
        chk("post_rst_cycles", 8'(n), 8'd8);
        chk("post_rst_state",  8'(state), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lock_access_ctrl.md
LOCK_ACCESS_CTRL -- requirements
Module: lock_access_ctrl

Interface
REQ-001 The block SHALL take parameter CODE0, default 3'b011, first code digit.
REQ-002 The block SHALL take parameter CODE1, default 3'b111, second code digit.
REQ-003 The block SHALL take parameter CODE2, default 3'b101, third code digit.
REQ-004 The block SHALL take parameter MAX_FAIL, default 3, consecutive failed entries that trigger lockout (legal 1..3).
REQ-005 The block SHALL take parameter OPEN_CYCLES, default 8, unlock hold time in cycles (legal 1..255).
REQ-006 The block SHALL take parameter LOCKOUT_CYCLES, default 16, lockout duration in cycles (legal 1..255).
REQ-007 The block SHALL take parameter ENTRY_TIMEOUT, default 32, idle cycles that abort a partial entry (legal 1..255).
REQ-008 The ports SHALL be:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- digit  in  3  keypad digit
- digit_valid  in  1  digit offered
- digit_ready  out  1  controller accepts a digit
- cancel  in  1  abort current entry
- unlock  out  1  lock open
- fail_pulse  out  1  one-cycle pulse per wrong 3-digit entry
- alarm_pulse  out  1  one-cycle pulse on lockout entry
- timeout_pulse  out  1  one-cycle pulse on entry timeout
- locked_out  out  1  lockout active
- fail_count  out  2  consecutive failures so far
- state  out  3  current FSM state

Function
REQ-009 The FSM SHALL have states IDLE=0, GOT1=1, GOT2=2, OPEN=3, LOCKOUT=4; codes 5-7 SHALL go to IDLE on the next edge.
REQ-010 A digit SHALL be accepted on a rising edge where digit_valid && digit_ready.
REQ-011 digit_ready SHALL be high exactly in IDLE, GOT1 and GOT2, combinationally from state only.
REQ-012 Each accepted digit SHALL be stored, and the first two digits SHALL move IDLE->GOT1->GOT2 with no early mismatch abort.
REQ-013 On the third accepted digit, in GOT2, all three stored digits SHALL be compared against CODE0..CODE2 in the same cycle.
REQ-014 On a match: next state OPEN, fail_count cleared to 0.
REQ-015 On a mismatch with fail_count+1 < MAX_FAIL: next state IDLE, fail_count incremented, fail_pulse high for the following cycle.
REQ-016 On a mismatch with fail_count+1 == MAX_FAIL: next state LOCKOUT, fail_pulse and alarm_pulse high for the following cycle, fail_count set to MAX_FAIL.
REQ-017 unlock SHALL equal (state==OPEN), giving a latency of 1 cycle from the third-digit accept edge.
REQ-018 unlock SHALL stay high for exactly OPEN_CYCLES cycles, then the FSM SHALL return to IDLE.
REQ-019 locked_out SHALL equal (state==LOCKOUT) and SHALL last exactly LOCKOUT_CYCLES cycles; on exit to IDLE, fail_count SHALL be cleared to 0.
REQ-020 An 8-bit down-counter SHALL time OPEN and LOCKOUT and SHALL be loaded with the duration on state entry.
REQ-021 A separate 8-bit idle counter SHALL run in GOT1/GOT2 and SHALL be cleared on every accepted digit.
REQ-022 When the idle counter reaches ENTRY_TIMEOUT, the FSM SHALL go to IDLE, pulse timeout_pulse one cycle and leave fail_count unchanged.
REQ-023 cancel in GOT1/GOT2 SHALL force IDLE on the next edge with no fail count and no pulse.
REQ-024 cancel in IDLE, OPEN or LOCKOUT SHALL be ignored.
REQ-025 A digit handshaking in the same cycle as cancel SHALL be consumed and discarded.
REQ-026 When cancel and timeout occur in the same cycle, cancel SHALL win and timeout_pulse SHALL stay low.
REQ-027 When a digit is accepted in the cycle the idle counter reaches ENTRY_TIMEOUT, the digit SHALL win and there SHALL be no timeout.
REQ-028 The pulse outputs SHALL be registered, and no two entries SHALL produce overlapping pulses.
REQ-029 fail_count SHALL saturate at MAX_FAIL and SHALL never wrap.
REQ-030 A correct entry SHALL clear fail_count regardless of prior failures below MAX_FAIL.

Reset
REQ-031 While reset is high, regardless of clk: state=IDLE, unlock=0, locked_out=0, all pulses=0, fail_count=0, counters=0, stored digits=0.
REQ-032 Reset asserted mid-OPEN or mid-LOCKOUT SHALL abort immediately.
REQ-033 After reset, the first accepted digit SHALL be treated as digit 1.

Verification
REQ-034 Enter 011,111,101 on consecutive cycles -> unlock high 1 cycle after the third accept, exactly 8 cycles, then state=0, fail_count=0.
REQ-035 Enter 011,111,100 -> fail_pulse one cycle, fail_count=1, state=0, unlock never high.
REQ-036 Three wrong entries -> third gives fail_pulse and alarm_pulse together, locked_out high 16 cycles, digit_ready=0 throughout, fail_count=0 after exit.
REQ-037 Enter 011, then no digit for 32 cycles -> timeout_pulse, state=0, fail_count unchanged.
REQ-038 Enter 011,111, then cancel with digit_valid=1 on digit 101 -> state=0, no unlock, no fail_pulse.
REQ-039 Assert reset at cycle 4 of OPEN -> unlock=0 asynchronously; then enter 011,111,101 -> unlock again, 8 cycles.
